// File: rtl/inv_addkey_col_serializer_pkg.sv
// Shared decryption-datapath definitions: state geometry, the column
// serializer FSM encoding and the common column-select helper, so that
// InvShiftRows and the column collector agree on byte ordering.
package inv_addkey_col_serializer_pkg;

    localparam int NCOL    = 4;
    localparam int COL_W   = 32;
    localparam int STATE_W = NCOL * COL_W;
    localparam int IDX_W   = $clog2(NCOL);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } col_ser_state_e;

    // Column 0 lives in the most significant word of the state, column
    // NCOL-1 in the least significant word.
    function automatic logic [COL_W-1:0] inv_col_select(
        input logic [STATE_W-1:0] state,
        input logic [IDX_W-1:0]   idx
    );
        return state[(NCOL - 1 - int'(idx)) * COL_W +: COL_W];
    endfunction

endpackage

// File: rtl/inv_addkey_col_serializer.sv
// AddRoundKey stage of the decryption datapath. A whole 128-bit state is
// XORed with its round key once on acceptance, held, and then streamed out
// as four 32-bit columns under a valid/ready handshake. A new block can be
// taken on the final column beat so that blocks follow with no bubble.
module inv_addkey_col_serializer
    import inv_addkey_col_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic [STATE_W-1:0] key_in,
    input  logic               last_round_in,
    output logic               col_valid,
    input  logic               col_ready,
    output logic [COL_W-1:0]   col_data,
    output logic [IDX_W-1:0]   col_idx,
    output logic               col_last,
    output logic               col_bypass
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOL - 1);

    col_ser_state_e     state_q;
    col_ser_state_e     state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [STATE_W-1:0] hold_q;
    logic               bypass_q;
    logic               load;

    // Handshake decode: the block is free when idle, or when the final
    // column is leaving this very cycle.
    always_comb begin
        col_valid = (state_q == EMIT);
        col_last  = col_valid && (idx_q == LAST_IDX);
        in_ready  = (state_q == IDLE) || (col_last && col_ready);
        load      = in_valid && in_ready;
    end

    // Next-state and column-counter logic for the IDLE/EMIT sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (in_valid) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (col_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (!in_valid) begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Sequencer state and column index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Capture the key-mixed state and the final-round flag once per block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q   <= '0;
            bypass_q <= 1'b0;
        end else if (load) begin
            hold_q   <= state_in ^ key_in;
            bypass_q <= last_round_in;
        end
    end

    // Output words come purely from registers, so there is no path from
    // state_in to col_data.
    always_comb begin
        col_data   = inv_col_select(hold_q, idx_q);
        col_idx    = idx_q;
        col_bypass = bypass_q;
    end

endmodule

// File: tb/tb_inv_addkey_col_serializer.sv
// Directed self-checking bench for the AddRoundKey column serializer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inv_addkey_col_serializer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         last_round_in;
    logic         col_valid;
    logic         col_ready;
    logic [31:0]  col_data;
    logic [1:0]   col_idx;
    logic         col_last;
    logic         col_bypass;

    int checks;
    int failures;

    localparam logic [127:0] BLK_A_STATE = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BLK_A_KEY   = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] BLK_A_EXP   = 128'h00102030_40506070_8090a0b0_c0d0e0f0;
    localparam logic [127:0] BLK_B_STATE = 128'hffffffff_00000000_12345678_9abcdef0;
    localparam logic [127:0] BLK_B_EXP   = 128'hffffffff_00000000_12345678_9abcdef0;

    inv_addkey_col_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .state_in      (state_in),
        .key_in        (key_in),
        .last_round_in (last_round_in),
        .col_valid     (col_valid),
        .col_ready     (col_ready),
        .col_data      (col_data),
        .col_idx       (col_idx),
        .col_last      (col_last),
        .col_bypass    (col_bypass)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present block A for one cycle with the given final-round flag.
    task automatic present_block_a(input logic last_flag);
        state_in      = BLK_A_STATE;
        key_in        = BLK_A_KEY;
        last_round_in = last_flag;
        in_valid      = 1'b1;
    endtask

    task automatic test_reset();
        logic [37:0] got;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        col_ready     = 1'b0;
        state_in      = '0;
        key_in        = '0;
        last_round_in = 1'b0;
        #2;
        got = {in_ready, col_valid, col_idx, col_last, col_bypass, col_data};
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", got,
                     {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (col_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release_valid: got %b expected 0", col_valid);
        end
    endtask

    task automatic test_basic();
        logic [36:0] got;
        logic [36:0] exp;
        @(negedge clk);
        present_block_a(1'b0);
        col_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            exp = {1'b1, 2'(i), (i == 3), 1'b0, BLK_A_EXP[127 - 32*i -: 32]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL basic_beat%0d: got %h expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (col_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_idle_after: got %b expected 0", col_valid);
        end
    endtask

    task automatic test_stall();
        logic [36:0] got;
        logic [36:0] exp;
        @(negedge clk);
        present_block_a(1'b0);
        col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        col_ready = 1'b0;
        exp = {1'b1, 2'd1, 1'b0, 1'b0, 32'h40506070};
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            checks++;
            if (got !== exp || in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got %h rdy %b expected %h rdy 0",
                         c, got, in_ready, exp);
            end
        end
        col_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            exp = {1'b1, 2'(i), (i == 3), 1'b0, BLK_A_EXP[127 - 32*i -: 32]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL stall_resume%0d: got %h expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (col_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_idle_after: got %b expected 0", col_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] got;
        logic [36:0] exp;
        @(negedge clk);
        present_block_a(1'b1);
        col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            exp = {1'b1, 2'(i), (i == 3), 1'b1, BLK_A_EXP[127 - 32*i -: 32]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL bypass_beat%0d: got %h expected %h", i, got, exp);
            end
        end
        state_in      = BLK_B_STATE;
        key_in        = '0;
        last_round_in = 1'b0;
        in_valid      = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            exp = {1'b1, 2'(i), (i == 3), 1'b0, BLK_B_EXP[127 - 32*i -: 32]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (col_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_idle_after: got %b expected 0", col_valid);
        end
    endtask

    task automatic test_busy_input();
        logic [36:0] got;
        logic [36:0] exp;
        @(negedge clk);
        present_block_a(1'b0);
        col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        state_in      = BLK_B_STATE;
        key_in        = 128'h01234567_89abcdef_01234567_89abcdef;
        last_round_in = 1'b1;
        in_valid      = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_in_ready: got %b expected 0", in_ready);
        end
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            got = {col_valid, col_idx, col_last, col_bypass, col_data};
            exp = {1'b1, 2'(i), (i == 3), 1'b0, BLK_A_EXP[127 - 32*i -: 32]};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("[TB] FAIL busy_beat%0d: got %h expected %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (col_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL busy_idle_after: got %b expected 0", col_valid);
        end
    endtask

    task automatic test_reset_mid_block();
        logic [37:0] got;
        @(negedge clk);
        present_block_a(1'b1);
        col_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (col_idx !== 2'd1 || col_data !== 32'h40506070) begin
            failures++;
            $display("[TB] FAIL rstmid_beat1: got idx %0d data %h expected idx 1 data 40506070",
                     col_idx, col_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = {in_ready, col_valid, col_idx, col_last, col_bypass, col_data};
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("[TB] FAIL rstmid_async: got %h expected %h", got,
                     {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            got = {in_ready, col_valid, col_idx, col_last, col_bypass, col_data};
            checks++;
            if (got !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0}) begin
                failures++;
                $display("[TB] FAIL rstmid_after%0d: got %h expected %h", c, got,
                         {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0});
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_busy_input();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_addkey_col_serializer.md
Name: inv_addkey_col_serializer

Overview:
- Sequential AddRoundKey stage of the decryption datapath.
- Accepts one 128-bit state plus its 128-bit round key, XORs them, and streams the result as four 32-bit columns to the downstream InvMixColumns column unit.
- A per-block flag marks the final round, in which the downstream unit bypasses InvMixColumns.
- Handshake-based: tolerates downstream stalls and accepts the next block back-to-back on the last beat.

Parameters:
- NCOL, 4, number of columns per state (fixed for AES; the counter width is derived from it).
- COL_W, 32, column width in bits; state width is NCOL*COL_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  state_in/key_in/last_round_in are valid
- in_ready  output  1  block can accept a new state this cycle
- state_in  input  128  cipher state; column 0 = [127:96], column 3 = [31:0]
- key_in  input  128  round key, same byte order as state_in
- last_round_in  input  1  block belongs to the final round (no InvMixColumns downstream)
- col_valid  output  1  col_data is valid
- col_ready  input  1  downstream consumes col_data this cycle
- col_data  output  32  (state ^ key) column word
- col_idx  output  2  column index of col_data, 0..3
- col_last  output  1  high on the column-3 beat
- col_bypass  output  1  registered last_round_in; constant across all 4 beats of a block

Behaviour:
- Reset (asynchronous, rst_n=0) clears all outputs: col_valid=0, col_data=0, col_idx=0, col_last=0, col_bypass=0. The FSM returns to IDLE and the holding register clears to 0.
- Reset assertion mid-block discards the block. No partial beats appear after release.
- Input handshake: transfer when in_valid && in_ready. in_ready is combinational: 1 in IDLE; in EMIT, 1 only when col_idx==3 && col_ready.
- On input transfer:
  - hold_q <= state_in ^ key_in (full 128-bit XOR, registered once).
  - bypass_q <= last_round_in.
  - col_idx <= 0; FSM -> EMIT.
  - First column is visible the next cycle (latency 1 cycle from accept to col_valid).
- Output handshake: a beat transfers when col_valid && col_ready. col_data = hold_q column selected by col_idx, driven from registers (no combinational path from state_in to col_data).
- While col_valid=1 && col_ready=0, col_data/col_idx/col_last/col_bypass hold stable.
- FSM states:
  - IDLE: col_valid=0. On in_valid -> EMIT.
  - EMIT: col_valid=1. On beat with col_idx<3, col_idx increments. On beat with col_idx==3:
    - if in_valid also high: load the new block, stay in EMIT, col_idx -> 0 (zero-bubble back-to-back).
    - otherwise: -> IDLE.
- Throughput: 4 cycles per block with continuous col_ready and in_valid.
- col_last = (col_idx==3) while col_valid.
- in_valid while busy (col_idx<3): ignored (in_ready=0). The upstream source must hold its data.
- No arithmetic carries. XOR only, widths exact, col_idx wraps 3->0 only via a new-block load.

Decomposition:
- Shared decryption package holds:
  - constants NCOL=4, COL_W=32, STATE_W=128
  - FSM state enum {IDLE, EMIT}
  - a column-select function (state, idx) -> 32-bit word, so that InvShiftRows and the column collector use the same byte ordering.
- No sub-module. The XOR is a single expression. The downstream InvMixColumns column unit is instantiated by the parent, not here.

Test Plan:
- Basic block: state_in=00112233_44556677_8899aabb_ccddeeff, key_in=00010203_04050607_08090a0b_0c0d0e0f, col_ready=1 -> col_data 00102030, 40506070, 8090a0b0, c0d0e0f0 on consecutive cycles; col_idx 0..3; col_last only on the 4th beat; first beat 1 cycle after accept.
- Stall: same block, col_ready=0 for 3 cycles on beat 1 -> col_data holds 40506070 and col_idx holds 1 throughout; in_ready stays 0; stream resumes with no beat lost.
- Back-to-back: second block (key=0, state=ffffffff_...) presented on the col_last cycle -> the next cycle shows col_data=ffffffff, col_idx=0, with no idle cycle.
- Bypass: last_round_in=1 with block 1 -> col_bypass=1 on all 4 beats. A following block with last_round_in=0 -> col_bypass=0 from its first beat.
- Reset mid-block: assert rst_n=0 after beat 1 -> outputs go to 0 immediately (asynchronous). After release: in_ready=1, col_valid=0 until a new in_valid.
- Busy input: in_valid pulsed with col_idx=1 -> not accepted (in_ready=0); the current block completes unchanged.
